// File: rtl/vcc_tok_pkg.sv
// ---------------------------------------------------------------------------
// vcc_tok_pkg
// Shared types and helpers for the C lexer front end.
//   tok_kind_e : kind of an emitted token (reserved / identifier / number / EOF)
//   op_code_e  : operator and keyword codes carried on tok_code for RESERVED
//   KW_STR_*   : keyword spellings, first character in bits [7:0], zero padded
//   KW_LEN_*   : keyword lengths in characters
//   is_digit / is_alpha / is_alnum / is_space : ASCII character classes
//   is_single_op / single_op_code : operators that are complete after one char
//   is_op2_lead / op2_sel         : operators that may take a trailing '='
// ---------------------------------------------------------------------------
package vcc_tok_pkg;

  typedef enum logic [1:0] {
    TK_RESERVED = 2'd0,
    TK_IDENT    = 2'd1,
    TK_NUM      = 2'd2,
    TK_EOF      = 2'd3
  } tok_kind_e;

  typedef enum logic [4:0] {
    OP_ADD     = 5'd0,
    OP_SUB     = 5'd1,
    OP_MUL     = 5'd2,
    OP_DIV     = 5'd3,
    OP_LPAR    = 5'd4,
    OP_RPAR    = 5'd5,
    OP_LBRC    = 5'd6,
    OP_RBRC    = 5'd7,
    OP_SEMI    = 5'd8,
    OP_ASSIGN  = 5'd9,
    OP_EQ      = 5'd10,
    OP_NE      = 5'd11,
    OP_LT      = 5'd12,
    OP_LE      = 5'd13,
    OP_GT      = 5'd14,
    OP_GE      = 5'd15,
    KW_RETURN  = 5'd16,
    KW_IF      = 5'd17,
    KW_ELSE    = 5'd18,
    KW_FOR     = 5'd19,
    KW_WHILE   = 5'd20
  } op_code_e;

  // Keyword spellings packed little-end first so they line up with the
  // identifier buffer, whose first character sits in the low byte.
  localparam logic [63:0] KW_STR_RETURN = 64'h0000_6E72_7574_6572;
  localparam logic [63:0] KW_STR_IF     = 64'h0000_0000_0000_6669;
  localparam logic [63:0] KW_STR_ELSE   = 64'h0000_0000_6573_6C65;
  localparam logic [63:0] KW_STR_FOR    = 64'h0000_0000_0072_6F66;
  localparam logic [63:0] KW_STR_WHILE  = 64'h0000_0065_6C69_6877;

  localparam int KW_LEN_RETURN = 6;
  localparam int KW_LEN_IF     = 2;
  localparam int KW_LEN_ELSE   = 4;
  localparam int KW_LEN_FOR    = 3;
  localparam int KW_LEN_WHILE  = 5;

  // Selector for the pending two-character operator lead.
  localparam logic [1:0] OP2_EQ  = 2'd0;
  localparam logic [1:0] OP2_LT  = 2'd1;
  localparam logic [1:0] OP2_GT  = 2'd2;
  localparam logic [1:0] OP2_NOT = 2'd3;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Underscore counts as a letter so it may start an identifier.
  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h5F);
  endfunction

  function automatic logic is_alnum(input logic [7:0] c);
    return is_alpha(c) || is_digit(c);
  endfunction

  function automatic logic is_space(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic is_single_op(input logic [7:0] c);
    return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F) ||
           (c == 8'h28) || (c == 8'h29) || (c == 8'h7B) || (c == 8'h7D) ||
           (c == 8'h3B);
  endfunction

  function automatic op_code_e single_op_code(input logic [7:0] c);
    case (c)
      8'h2D:   return OP_SUB;
      8'h2A:   return OP_MUL;
      8'h2F:   return OP_DIV;
      8'h28:   return OP_LPAR;
      8'h29:   return OP_RPAR;
      8'h7B:   return OP_LBRC;
      8'h7D:   return OP_RBRC;
      8'h3B:   return OP_SEMI;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic is_op2_lead(input logic [7:0] c);
    return (c == 8'h3D) || (c == 8'h3C) || (c == 8'h3E) || (c == 8'h21);
  endfunction

  function automatic logic [1:0] op2_sel(input logic [7:0] c);
    case (c)
      8'h3C:   return OP2_LT;
      8'h3E:   return OP2_GT;
      8'h21:   return OP2_NOT;
      default: return OP2_EQ;
    endcase
  endfunction

endpackage

// File: rtl/tok_kw_match.sv
// ---------------------------------------------------------------------------
// tok_kw_match
// Combinational keyword recogniser for a finished identifier.
//   i_buf   : identifier chars, first char in [7:0], zero padded
//   i_len   : identifier length in chars
//   o_isKw  : identifier is exactly one of return/if/else/for/while
//   o_code  : matching KW_* code (OP_ADD when o_isKw is 0)
// ---------------------------------------------------------------------------
module tok_kw_match
  import vcc_tok_pkg::*;
#(
  parameter int ID_MAX = 8,
  parameter int LEN_W  = 4
) (
  input  logic [8*ID_MAX-1:0] i_buf,
  input  logic [LEN_W-1:0]    i_len,
  output logic                o_isKw,
  output op_code_e            o_code
);

  // Keywords fit in eight chars, so only the first eight buffer bytes matter;
  // the length check rules out longer identifiers with a matching prefix.
  logic [63:0] w_buf8;

  for (genvar k = 0; k < 8; k++) begin : g_byte
    if (k < ID_MAX) begin : g_used
      assign w_buf8[8*k +: 8] = i_buf[8*k +: 8];
    end else begin : g_pad
      assign w_buf8[8*k +: 8] = 8'h00;
    end
  end

  always_comb begin
    o_isKw = 1'b0;
    o_code = OP_ADD;
    if ((i_len == LEN_W'(KW_LEN_RETURN)) && (w_buf8 == KW_STR_RETURN)) begin
      o_isKw = 1'b1;
      o_code = KW_RETURN;
    end else if ((i_len == LEN_W'(KW_LEN_IF)) && (w_buf8 == KW_STR_IF)) begin
      o_isKw = 1'b1;
      o_code = KW_IF;
    end else if ((i_len == LEN_W'(KW_LEN_ELSE)) && (w_buf8 == KW_STR_ELSE)) begin
      o_isKw = 1'b1;
      o_code = KW_ELSE;
    end else if ((i_len == LEN_W'(KW_LEN_FOR)) && (w_buf8 == KW_STR_FOR)) begin
      o_isKw = 1'b1;
      o_code = KW_FOR;
    end else if ((i_len == LEN_W'(KW_LEN_WHILE)) && (w_buf8 == KW_STR_WHILE)) begin
      o_isKw = 1'b1;
      o_code = KW_WHILE;
    end
  end

endmodule

// File: rtl/c_tokenizer.sv
// ---------------------------------------------------------------------------
// c_tokenizer
// Byte-serial C lexer producing a token stream for the parser stage.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : source byte handshake (in_ready is a peek signal:
//   in_char, in_last        a token-terminating char is left unconsumed)
//   tok_valid/tok_ready   : single-slot token output handshake
//   tok_kind/code/num/ident/pos : token payload
//   err, err_pos          : sticky lexical error and offending byte offset
// Build option TOKENIZER_LINECOL_EN adds tok_line/tok_col (1-based position
// of the token start); without it those ports and counters do not exist.
// ---------------------------------------------------------------------------
module c_tokenizer
  import vcc_tok_pkg::*;
#(
  parameter int NUM_W  = 32,
  parameter int ID_MAX = 8,
  parameter int POS_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_char,
  input  logic                in_last,
  output logic                tok_valid,
  input  logic                tok_ready,
  output logic [1:0]          tok_kind,
  output logic [4:0]          tok_code,
  output logic [NUM_W-1:0]    tok_num,
  output logic [8*ID_MAX-1:0] tok_ident,
  output logic [POS_W-1:0]    tok_pos,
  output logic                err,
  output logic [POS_W-1:0]    err_pos
`ifdef TOKENIZER_LINECOL_EN
  ,
  output logic [15:0]         tok_line,
  output logic [15:0]         tok_col
`endif
);

  localparam int LEN_W = $clog2(ID_MAX + 1);

  localparam logic [2:0] S_SCAN  = 3'd0;
  localparam logic [2:0] S_NUM   = 3'd1;
  localparam logic [2:0] S_IDENT = 3'd2;
  localparam logic [2:0] S_OP2   = 3'd3;
  localparam logic [2:0] S_EOFP  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]          r_state;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    r_start;
  logic [NUM_W-1:0]    r_acc;
  logic [8*ID_MAX-1:0] r_ibuf;
  logic [LEN_W-1:0]    r_ilen;
  logic [1:0]          r_op2;
  logic                r_eofPend;
  logic                r_tokValid;
  logic [1:0]          r_tokKind;
  logic [4:0]          r_tokCode;
  logic [NUM_W-1:0]    r_tokNum;
  logic [8*ID_MAX-1:0] r_tokIdent;
  logic [POS_W-1:0]    r_tokPos;
  logic                r_err;
  logic [POS_W-1:0]    r_errPos;

  logic                w_canLoad;
  logic                w_inReady;
  logic                w_fire;
  logic                w_emit;
  logic                w_goErr;
  logic [2:0]          w_next;
  logic [POS_W-1:0]    w_errPos;
  logic [1:0]          w_kind;
  op_code_e            w_code;
  logic [NUM_W-1:0]    w_num;
  logic [8*ID_MAX-1:0] w_ident;
  logic [POS_W-1:0]    w_tpos;
  logic                w_isKw;
  op_code_e            w_kwCode;
  logic [NUM_W-1:0]    w_digitVal;

  tok_kw_match #(
    .ID_MAX (ID_MAX),
    .LEN_W  (LEN_W)
  ) u_kwMatch (
    .i_buf  (r_ibuf),
    .i_len  (r_ilen),
    .o_isKw (w_isKw),
    .o_code (w_kwCode)
  );

  // The output slot may take a new token when it is empty or being drained.
  assign w_canLoad  = !r_tokValid || tok_ready;
  assign w_digitVal = NUM_W'(in_char[3:0]);
  assign in_ready   = w_inReady && !rst;
  assign w_fire     = in_valid && in_ready;

  // Next-step decision: whether the current byte is consumed, whether a
  // token is emitted, and where the FSM goes. Emission that cannot load
  // leaves everything untouched, which stalls the byte stream.
  always_comb begin
    w_inReady = 1'b0;
    w_emit    = 1'b0;
    w_goErr   = 1'b0;
    w_next    = r_state;
    w_errPos  = r_pos;
    w_kind    = TK_RESERVED;
    w_code    = OP_ADD;
    w_num     = '0;
    w_ident   = '0;
    w_tpos    = r_start;
    case (r_state)
      S_SCAN: begin
        if (in_valid) begin
          if (is_space(in_char)) begin
            w_inReady = 1'b1;
            if (in_last) w_next = S_EOFP;
          end else if (is_digit(in_char)) begin
            w_inReady = 1'b1;
            w_next    = S_NUM;
          end else if (is_alpha(in_char)) begin
            w_inReady = 1'b1;
            w_next    = S_IDENT;
          end else if (is_single_op(in_char)) begin
            if (w_canLoad) begin
              w_inReady = 1'b1;
              w_emit    = 1'b1;
              w_code    = single_op_code(in_char);
              w_tpos    = r_pos;
              w_next    = in_last ? S_EOFP : S_SCAN;
            end
          end else if (is_op2_lead(in_char)) begin
            w_inReady = 1'b1;
            w_next    = S_OP2;
          end else begin
            w_goErr = 1'b1;
            w_next  = S_ERR;
          end
        end
      end
      S_NUM: begin
        // After the source's last byte no further char can extend the literal.
        if (r_eofPend || (in_valid && !is_digit(in_char))) begin
          if (w_canLoad) begin
            w_emit = 1'b1;
            w_kind = TK_NUM;
            w_num  = r_acc;
            w_next = r_eofPend ? S_EOFP : S_SCAN;
          end
        end else if (in_valid) begin
          w_inReady = 1'b1;
        end
      end
      S_IDENT: begin
        if (r_eofPend || (in_valid && !is_alnum(in_char))) begin
          if (w_canLoad) begin
            w_emit  = 1'b1;
            w_kind  = w_isKw ? TK_RESERVED : TK_IDENT;
            w_code  = w_isKw ? w_kwCode : OP_ADD;
            w_ident = w_isKw ? '0 : r_ibuf;
            w_next  = r_eofPend ? S_EOFP : S_SCAN;
          end
        end else if (in_valid) begin
          if (r_ilen == LEN_W'(ID_MAX)) begin
            w_goErr = 1'b1;
            w_next  = S_ERR;
          end else begin
            w_inReady = 1'b1;
          end
        end
      end
      S_OP2: begin
        if (!r_eofPend && in_valid && (in_char == 8'h3D)) begin
          if (w_canLoad) begin
            w_inReady = 1'b1;
            w_emit    = 1'b1;
            case (r_op2)
              OP2_LT:  w_code = OP_LE;
              OP2_GT:  w_code = OP_GE;
              OP2_NOT: w_code = OP_NE;
              default: w_code = OP_EQ;
            endcase
            w_next = in_last ? S_EOFP : S_SCAN;
          end
        end else if (r_eofPend || in_valid) begin
          // A lone '!' has no meaning; report it at the '!' itself.
          if (r_op2 == OP2_NOT) begin
            w_goErr  = 1'b1;
            w_errPos = r_start;
            w_next   = S_ERR;
          end else if (w_canLoad) begin
            w_emit = 1'b1;
            case (r_op2)
              OP2_LT:  w_code = OP_LT;
              OP2_GT:  w_code = OP_GT;
              default: w_code = OP_ASSIGN;
            endcase
            w_next = r_eofPend ? S_EOFP : S_SCAN;
          end
        end
      end
      S_EOFP: begin
        if (w_canLoad) begin
          w_emit = 1'b1;
          w_kind = TK_EOF;
          w_tpos = r_pos;
          w_next = S_SCAN;
        end
      end
      default: begin
      end
    endcase
  end

  // State, lexeme accumulation and the single-slot output register. Starting
  // values for acc/ident/op2 are loaded on every SCAN consume; only the one
  // matching the next state is ever read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_SCAN;
      r_pos      <= '0;
      r_start    <= '0;
      r_acc      <= '0;
      r_ibuf     <= '0;
      r_ilen     <= '0;
      r_op2      <= OP2_EQ;
      r_eofPend  <= 1'b0;
      r_tokValid <= 1'b0;
      r_tokKind  <= '0;
      r_tokCode  <= '0;
      r_tokNum   <= '0;
      r_tokIdent <= '0;
      r_tokPos   <= '0;
      r_err      <= 1'b0;
      r_errPos   <= '0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_pos <= r_pos + POS_W'(1);
        if (in_last) r_eofPend <= 1'b1;
        case (r_state)
          S_SCAN: begin
            r_start <= r_pos;
            r_acc   <= w_digitVal;
            r_ibuf  <= {{(8*ID_MAX-8){1'b0}}, in_char};
            r_ilen  <= LEN_W'(1);
            r_op2   <= op2_sel(in_char);
          end
          S_NUM: begin
            r_acc <= (r_acc << 3) + (r_acc << 1) + w_digitVal;
          end
          S_IDENT: begin
            for (int k = 0; k < ID_MAX; k++) begin
              if (r_ilen == LEN_W'(k)) r_ibuf[8*k +: 8] <= in_char;
            end
            r_ilen <= r_ilen + LEN_W'(1);
          end
          default: begin
          end
        endcase
      end
      if (w_goErr) begin
        r_err      <= 1'b1;
        r_errPos   <= w_errPos;
        r_tokValid <= 1'b0;
      end else if (w_emit) begin
        r_tokValid <= 1'b1;
        r_tokKind  <= w_kind;
        r_tokCode  <= w_code;
        r_tokNum   <= w_num;
        r_tokIdent <= w_ident;
        r_tokPos   <= w_tpos;
      end else if (tok_ready) begin
        r_tokValid <= 1'b0;
      end
      // EOF closes this source; the next one starts counting from zero.
      if (w_emit && (r_state == S_EOFP)) begin
        r_pos     <= '0;
        r_eofPend <= 1'b0;
      end
    end
  end

  assign tok_valid = r_tokValid;
  assign tok_kind  = r_tokKind;
  assign tok_code  = r_tokCode;
  assign tok_num   = r_tokNum;
  assign tok_ident = r_tokIdent;
  assign tok_pos   = r_tokPos;
  assign err       = r_err;
  assign err_pos   = r_errPos;

`ifdef TOKENIZER_LINECOL_EN
  logic [15:0] r_line;
  logic [15:0] r_col;
  logic [15:0] r_startLine;
  logic [15:0] r_startCol;
  logic [15:0] r_tokLine;
  logic [15:0] r_tokCol;

  // Line/column of the next byte, plus the start of the lexeme in flight.
  // Tokens decided in NUM/IDENT/OP2 report the saved start; SCAN and EOFP
  // tokens start at the current position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line      <= 16'd1;
      r_col       <= 16'd1;
      r_startLine <= 16'd1;
      r_startCol  <= 16'd1;
      r_tokLine   <= '0;
      r_tokCol    <= '0;
    end else begin
      if (w_fire) begin
        if (r_state == S_SCAN) begin
          r_startLine <= r_line;
          r_startCol  <= r_col;
        end
        if (in_char == 8'h0A) begin
          r_line <= r_line + 16'd1;
          r_col  <= 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
      if (!w_goErr && w_emit) begin
        if ((r_state == S_SCAN) || (r_state == S_EOFP)) begin
          r_tokLine <= r_line;
          r_tokCol  <= r_col;
        end else begin
          r_tokLine <= r_startLine;
          r_tokCol  <= r_startCol;
        end
      end
      if (w_emit && (r_state == S_EOFP)) begin
        r_line <= 16'd1;
        r_col  <= 16'd1;
      end
    end
  end

  assign tok_line = r_tokLine;
  assign tok_col  = r_tokCol;
`endif

endmodule

// File: tb/tb_c_tokenizer.sv
// ---------------------------------------------------------------------------
// tb_c_tokenizer
// Scoreboard bench for c_tokenizer: expected tokens are queued as each source
// string is driven and compared as the lexer hands them over.
// ---------------------------------------------------------------------------
module tb_c_tokenizer;

  // Token kinds and codes as the parser expects them.
  localparam logic [1:0] K_RES = 2'd0;
  localparam logic [1:0] K_ID  = 2'd1;
  localparam logic [1:0] K_NUM = 2'd2;
  localparam logic [1:0] K_EOF = 2'd3;

  localparam logic [4:0] C_ADD = 5'd0,  C_SUB = 5'd1,  C_MUL = 5'd2,  C_DIV = 5'd3;
  localparam logic [4:0] C_LPAR = 5'd4, C_RPAR = 5'd5, C_LBRC = 5'd6, C_RBRC = 5'd7;
  localparam logic [4:0] C_SEMI = 5'd8, C_ASSIGN = 5'd9, C_EQ = 5'd10, C_NE = 5'd11;
  localparam logic [4:0] C_LT = 5'd12,  C_LE = 5'd13,  C_GT = 5'd14,  C_GE = 5'd15;
  localparam logic [4:0] C_RET = 5'd16, C_IF = 5'd17,  C_ELSE = 5'd18, C_FOR = 5'd19;
  localparam logic [4:0] C_WHILE = 5'd20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        in_last;
  logic        tok_valid;
  logic        tok_ready;
  logic [1:0]  tok_kind;
  logic [4:0]  tok_code;
  logic [31:0] tok_num;
  logic [63:0] tok_ident;
  logic [15:0] tok_pos;
  logic        err;
  logic [15:0] err_pos;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  code;
    logic [31:0] num;
    logic [63:0] ident;
    logic [15:0] pos;
  } tok_t;

  tok_t expQ[$];
  tok_t monE;
  int   checkCount = 0;
  int   passCount  = 0;

  c_tokenizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_last   (in_last),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_kind  (tok_kind),
    .tok_code  (tok_code),
    .tok_num   (tok_num),
    .tok_ident (tok_ident),
    .tok_pos   (tok_pos),
    .err       (err),
    .err_pos   (err_pos)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports each mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [63:0] packIdent(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 8; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic pushTok(input logic [1:0] k, input logic [4:0] c, input logic [31:0] n,
                         input string id, input logic [15:0] p);
    tok_t t;
    t.kind  = k;
    t.code  = c;
    t.num   = n;
    t.ident = packIdent(id);
    t.pos   = p;
    expQ.push_back(t);
  endtask

  // Feed a string byte by byte; in_last marks the final byte when asked.
  // With expectErr a byte that is never taken simply ends the feed.
  task automatic applyStimulus(input string s, input bit lastFlag, input bit expectErr);
    int waited;
    bit accepted;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = s[i];
      in_last  = lastFlag && (i == s.len() - 1);
      waited   = 0;
      accepted = 1'b0;
      while (!accepted && waited < 64) begin
        #1;
        if (in_ready) begin
          accepted = 1'b1;
          @(posedge clk);
        end else begin
          @(negedge clk);
          waited++;
        end
      end
      if (!accepted) begin
        if (!expectErr) checkOutput("inAccept", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
  endtask

  task automatic doReset(input bit doChecks);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_char  = "a";
    in_last  = 1'b0;
    #1;
    if (doChecks) checkOutput("rstInReady", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    #1;
    if (doChecks) begin
      checkOutput("rstTokValid", {63'b0, tok_valid}, 64'd0);
      checkOutput("rstErr",      {63'b0, err}, 64'd0);
      checkOutput("rstErrPos",   {48'b0, err_pos}, 64'd0);
      checkOutput("rstKind",     {62'b0, tok_kind}, 64'd0);
      checkOutput("rstPos",      {48'b0, tok_pos}, 64'd0);
      checkOutput("rstNum",      {32'b0, tok_num}, 64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Token monitor: a token is taken at the posedge following a negedge
  // where valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && tok_valid && tok_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extraTok", {63'b0, tok_valid}, 64'd0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("kind",  {62'b0, tok_kind}, {62'b0, monE.kind});
          checkOutput("code",  {59'b0, tok_code}, {59'b0, monE.code});
          checkOutput("num",   {32'b0, tok_num},  {32'b0, monE.num});
          checkOutput("ident", tok_ident, monE.ident);
          checkOutput("pos",   {48'b0, tok_pos},  {48'b0, monE.pos});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    in_last   = 1'b0;
    tok_ready = 1'b1;
    repeat (2) @(negedge clk);
    doReset(1'b1);

    $display("[TB] basic assignment");
    pushTok(K_ID, 5'd0, 0, "a", 0);
    pushTok(K_RES, C_ASSIGN, 0, "", 1);
    pushTok(K_NUM, 5'd0, 12, "", 2);
    pushTok(K_RES, C_SEMI, 0, "", 4);
    pushTok(K_EOF, 5'd0, 0, "", 5);
    applyStimulus("a=12;", 1'b1, 1'b0);
    drain();

    $display("[TB] two-char operators with peek");
    pushTok(K_ID, 5'd0, 0, "x", 0);
    pushTok(K_RES, C_LE, 0, "", 1);
    pushTok(K_ID, 5'd0, 0, "y", 3);
    pushTok(K_RES, C_NE, 0, "", 4);
    pushTok(K_NUM, 5'd0, 3, "", 6);
    pushTok(K_EOF, 5'd0, 0, "", 7);
    applyStimulus("x<=y!=3", 1'b1, 1'b0);
    drain();

    $display("[TB] keywords");
    pushTok(K_RES, C_WHILE, 0, "", 0);
    pushTok(K_ID, 5'd0, 0, "iff", 6);
    pushTok(K_RES, C_RET, 0, "", 10);
    pushTok(K_EOF, 5'd0, 0, "", 16);
    applyStimulus("while iff return", 1'b1, 1'b0);
    drain();

    $display("[TB] boundaries: max ident, wrap, last on newline");
    pushTok(K_ID, 5'd0, 0, "if_", 0);
    pushTok(K_ID, 5'd0, 0, "abcdefgh", 4);
    pushTok(K_NUM, 5'd0, 1, "", 13);
    pushTok(K_EOF, 5'd0, 0, "", 24);
    applyStimulus("if_ abcdefgh 4294967297\n", 1'b1, 1'b0);
    drain();

    $display("[TB] single-char operators");
    pushTok(K_RES, C_LBRC, 0, "", 0);
    pushTok(K_RES, C_LPAR, 0, "", 1);
    pushTok(K_ID, 5'd0, 0, "b", 2);
    pushTok(K_RES, C_GE, 0, "", 3);
    pushTok(K_ID, 5'd0, 0, "c", 5);
    pushTok(K_RES, C_RPAR, 0, "", 6);
    pushTok(K_RES, C_SUB, 0, "", 7);
    pushTok(K_ID, 5'd0, 0, "d", 8);
    pushTok(K_RES, C_MUL, 0, "", 9);
    pushTok(K_ID, 5'd0, 0, "e", 10);
    pushTok(K_RES, C_DIV, 0, "", 11);
    pushTok(K_ID, 5'd0, 0, "f", 12);
    pushTok(K_RES, C_RBRC, 0, "", 13);
    pushTok(K_EOF, 5'd0, 0, "", 14);
    applyStimulus("{(b>=c)-d*e/f}", 1'b1, 1'b0);
    drain();

    $display("[TB] else/for, EQ, LT, trailing GT at last byte");
    pushTok(K_RES, C_ELSE, 0, "", 0);
    pushTok(K_RES, C_FOR, 0, "", 5);
    pushTok(K_RES, C_ADD, 0, "", 8);
    pushTok(K_ID, 5'd0, 0, "z", 9);
    pushTok(K_RES, C_EQ, 0, "", 10);
    pushTok(K_NUM, 5'd0, 1, "", 12);
    pushTok(K_RES, C_LT, 0, "", 13);
    pushTok(K_NUM, 5'd0, 2, "", 14);
    pushTok(K_RES, C_GT, 0, "", 15);
    pushTok(K_EOF, 5'd0, 0, "", 16);
    applyStimulus("else for+z==1<2>", 1'b1, 1'b0);
    drain();

    $display("[TB] output backpressure");
    pushTok(K_ID, 5'd0, 0, "a", 0);
    pushTok(K_RES, C_ASSIGN, 0, "", 1);
    pushTok(K_NUM, 5'd0, 12, "", 2);
    pushTok(K_RES, C_SEMI, 0, "", 4);
    pushTok(K_EOF, 5'd0, 0, "", 5);
    fork
      applyStimulus("a=12;", 1'b1, 1'b0);
      begin
        w = 0;
        while (w < 50) begin
          @(negedge clk);
          if (tok_valid) begin
            tok_ready = 1'b0;
            break;
          end
          w++;
        end
        repeat (10) @(negedge clk);
        #1;
        checkOutput("stallValid",   {63'b0, tok_valid}, 64'd1);
        checkOutput("stallKind",    {62'b0, tok_kind}, {62'b0, K_ID});
        checkOutput("stallIdent",   tok_ident, packIdent("a"));
        checkOutput("stallPos",     {48'b0, tok_pos}, 64'd0);
        checkOutput("stallInReady", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        tok_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] illegal byte");
    doReset(1'b0);
    pushTok(K_NUM, 5'd0, 1, "", 0);
    applyStimulus("1 $", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("errFlag",    {63'b0, err}, 64'd1);
    checkOutput("errPos",     {48'b0, err_pos}, 64'd2);
    checkOutput("errInReady", {63'b0, in_ready}, 64'd0);
    checkOutput("errTokValid", {63'b0, tok_valid}, 64'd0);
    drain();

    $display("[TB] identifier too long");
    doReset(1'b0);
    applyStimulus("abcdefghi", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("longErr",    {63'b0, err}, 64'd1);
    checkOutput("longErrPos", {48'b0, err_pos}, 64'd8);
    drain();

    $display("[TB] reset mid number");
    doReset(1'b0);
    applyStimulus("99", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    doReset(1'b0);
    pushTok(K_NUM, 5'd0, 7, "", 0);
    pushTok(K_RES, C_SEMI, 0, "", 1);
    pushTok(K_EOF, 5'd0, 0, "", 2);
    applyStimulus("7;", 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
